// File: rtl/cidx_fb_pkg.sv
// Shared types for the colour-index framebuffer writer.
// Holds the cidx_t type, index limits, FSM state enum and S1 pipeline bundle.
package cidx_fb_pkg;

    typedef logic [8:0] cidx_t;

    localparam cidx_t CIDX_MIN = 9'd0;
    localparam cidx_t CIDX_MAX = 9'd511;

    // S1 carries a fixed-width address so the struct is independent of
    // the framebuffer geometry; the writer zero-extends into it.
    localparam int ADDR_MAX_W = 32;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } fb_state_e;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_MAX_W-1:0] addr;
        cidx_t                 cidx;
    } s1_t;

    function automatic cidx_t cidx_max(input cidx_t a, input cidx_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cidx_fb_clear_seq.sv
// Framebuffer clear sweep sequencer: address counter, busy flag, done pulse.
// Ports: clk, rst_n, start (begin sweep), busy, addr (sweep address), done.
module cidx_fb_clear_seq
    import cidx_fb_pkg::*;
#(
    parameter int N  = 16384,
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic [AW-1:0] addr,
    output logic          done
);

    logic [AW-1:0] cnt_q;
    logic          busy_q;

    assign busy = busy_q;
    assign addr = cnt_q;
    assign done = busy_q && (cnt_q == AW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            if (done) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cidx_fb_writer.sv
// Colour-index framebuffer writer: read-modify-write keeping the max index
// per pixel, with a full-framebuffer clear sweep.
// Ports: in_valid/in_ready/in_x/in_y/in_cidx pixel port, clr_start/busy clear
// control, upd_count changed-word counter, ram_* read and write RAM ports.
// Optional macro FB_FWD_EN: forward S1 result to a same-address S0 pixel
// instead of stalling it for one cycle.
module cidx_fb_writer
    import cidx_fb_pkg::*;
#(
    parameter  int FB_W = 128,
    parameter  int FB_H = 128,
    localparam int XW   = $clog2(FB_W),
    localparam int YW   = $clog2(FB_H),
    localparam int AW   = XW + YW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    input  logic [YW-1:0] in_y,
    input  logic [8:0]    in_cidx,
    input  logic          clr_start,
    output logic          busy,
    output logic [15:0]   upd_count,
    output logic          ram_re,
    output logic [AW-1:0] ram_raddr,
    input  logic [8:0]    ram_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [8:0]    ram_wdata
);

    localparam int N = FB_W * FB_H;

    fb_state_e state_q, state_d;
    s1_t       s1_q, s1_d;

    logic                  rdy_q;
    logic [AW-1:0]         in_addr;
    logic [ADDR_MAX_W-1:0] in_addr_w;
    logic                  addr_hit;
    logic                  hazard;
    logic                  accept;
    logic                  clr_go;
    logic                  clr_busy;
    logic                  clr_done;
    logic [AW-1:0]         clr_addr;
    cidx_t                 old_val;
    cidx_t                 s1_res;
    logic                  s1_wr;

`ifdef FB_FWD_EN
    logic  fwd_sel_q;
    cidx_t fwd_val_q;
`endif

    assign in_addr   = {in_y, in_x};
    assign in_addr_w = ADDR_MAX_W'(in_addr);
    assign addr_hit  = s1_q.valid && (s1_q.addr == in_addr_w);

`ifdef FB_FWD_EN
    assign hazard  = 1'b0;
    assign old_val = fwd_sel_q ? fwd_val_q : ram_rdata;
`else
    // The RAM write for S1 lands at the end of this cycle, so a pixel
    // to the same address must wait one cycle to read the new value.
    assign hazard  = addr_hit;
    assign old_val = ram_rdata;
`endif

    assign s1_wr  = s1_q.valid && (s1_q.cidx > old_val);
    assign s1_res = cidx_max(s1_q.cidx, old_val);

    // rdy_q holds in_ready low through reset and until the first edge after.
    assign in_ready = rdy_q && (state_q == ST_IDLE)
                      && !clr_start && !hazard;
    assign accept   = in_valid && in_ready;
    assign clr_go   = (state_q == ST_IDLE) && clr_start;
    assign busy     = clr_busy;

    cidx_fb_clear_seq #(
        .N  (N),
        .AW (AW)
    ) u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .start (clr_go),
        .busy  (clr_busy),
        .addr  (clr_addr),
        .done  (clr_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (clr_start) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_done)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_d       = s1_q;
        s1_d.valid = accept;
        if (accept) begin
            s1_d.addr = in_addr_w;
            s1_d.cidx = in_cidx;
        end
    end

    always_comb begin
        ram_re    = accept;
        ram_raddr = accept ? in_addr : '0;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = CIDX_MIN;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = CIDX_MIN;
        end else if (s1_wr) begin
            ram_we    = 1'b1;
            ram_waddr = s1_q.addr[AW-1:0];
            ram_wdata = s1_q.cidx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s1_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            rdy_q   <= 1'b1;
        end
    end

    // Counter restarts as the sweep begins; sweep writes never count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_count <= '0;
        end else if (clr_go) begin
            upd_count <= '0;
        end else if (s1_wr && (upd_count != 16'hFFFF)) begin
            upd_count <= upd_count + 16'd1;
        end
    end

`ifdef FB_FWD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel_q <= 1'b0;
            fwd_val_q <= CIDX_MIN;
        end else begin
            fwd_sel_q <= accept && addr_hit;
            fwd_val_q <= s1_res;
        end
    end
`else
    // Result only consumed by the forwarding path.
    logic unused_res;
    assign unused_res = ^s1_res;
`endif

endmodule

// File: tb/tb_cidx_fb_writer.sv
// Self-checking bench for cidx_fb_writer with a behavioural RAM model.
// Directed vector table plus clear, reset and random scoreboard sequences.
module tb_cidx_fb_writer;

    localparam int FB_W = 16;
    localparam int FB_H = 8;
    localparam int XW   = 4;
    localparam int YW   = 3;
    localparam int AW   = 7;
    localparam int N    = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;
    logic [8:0]    in_cidx;
    logic          clr_start;
    logic          busy;
    logic [15:0]   upd_count;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [8:0]    ram_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [8:0]    ram_wdata;

    logic [8:0]    mem [N];
    logic          fill_en = 1'b0;
    logic [8:0]    fill_val = '0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [8:0]    pl_data = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cidx_fb_writer #(.FB_W(FB_W), .FB_H(FB_H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_cidx   (in_cidx),
        .clr_start (clr_start),
        .busy      (busy),
        .upd_count (upd_count),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata)
    );

    // RAM: registered read, read-before-write on collision.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < N; i++) mem[i] <= fill_val;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
        if (ram_re) ram_rdata <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [8:0] v);
        fill_en  = 1'b1;
        fill_val = v;
        tick();
        fill_en  = 1'b0;
    endtask

    task automatic preload(input int a, input int d);
        pl_en   = 1'b1;
        pl_addr = AW'(a);
        pl_data = 9'(d);
        tick();
        pl_en   = 1'b0;
    endtask

    typedef struct {
        int x;
        int y;
        int c;
        int pre;
        int we;
    } vec_t;

    vec_t       vt [10];
    int         exp_upd;
    logic [8:0] refm [N];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int a;
        int wt;
        int err;
        int acc;
        int cyc;
        int mism;

        vt[0] = '{3, 2, 100, 0,   1};
        vt[1] = '{3, 2, 150, 200, 0};
        vt[2] = '{3, 2, 200, 200, 0};
        vt[3] = '{3, 2, 511, 200, 1};
        vt[4] = '{0, 0, 0,   0,   0};
        vt[5] = '{15, 7, 1,  0,   1};
        vt[6] = '{15, 7, 511, 511, 0};
        vt[7] = '{5, 1, 300, 299, 1};
        vt[8] = '{5, 1, 299, 300, 0};
        vt[9] = '{9, 4, 256, 255, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_x      = 4'd3;
        in_y      = 3'd2;
        in_cidx   = 9'd100;
        clr_start = 1'b0;
        #2;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd", upd_count, 0);
        chk("rst_re", ram_re, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_raddr", ram_raddr, 0);
        chk("rst_waddr", ram_waddr, 0);
        chk("rst_wdata", ram_wdata, 0);
        in_valid = 1'b0;
        fill(9'd0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        exp_upd = 0;
        for (int i = 0; i < 10; i++) begin
            a = vt[i].y * FB_W + vt[i].x;
            preload(a, vt[i].pre);
            in_valid = 1'b1;
            in_x     = XW'(vt[i].x);
            in_y     = YW'(vt[i].y);
            in_cidx  = 9'(vt[i].c);
            @(negedge clk);
            chk("vec_ready", in_ready, 1);
            chk("vec_re", ram_re, 1);
            chk("vec_raddr", ram_raddr, a);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            chk("vec_we", ram_we, vt[i].we);
            if (vt[i].we != 0) begin
                chk("vec_waddr", ram_waddr, a);
                chk("vec_wdata", ram_wdata, vt[i].c);
            end
            exp_upd += vt[i].we;
            tick();
            chk("vec_upd", upd_count, exp_upd);
            chk("vec_mem", mem[a], vt[i].we != 0 ? vt[i].c : vt[i].pre);
        end

        // Back-to-back same address, 10 then 20.
        preload(55, 0);
        in_valid = 1'b1;
        in_x     = 4'd7;
        in_y     = 3'd3;
        in_cidx  = 9'd10;
        @(negedge clk);
        chk("b2b_first_ready", in_ready, 1);
        tick();
        in_cidx = 9'd20;
        @(negedge clk);
        chk("b2b_we10", ram_we, 1);
        chk("b2b_wdata10", ram_wdata, 10);
        wt = 0;
        while (!in_ready && wt < 4) begin
            tick();
            @(negedge clk);
            wt++;
        end
`ifdef FB_FWD_EN
        chk("b2b_stall", wt, 0);
`else
        chk("b2b_stall", wt, 1);
`endif
        chk("b2b_accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_we20", ram_we, 1);
        chk("b2b_wdata20", ram_wdata, 20);
        tick();
        tick();
        exp_upd += 2;
        chk("b2b_mem", mem[55], 20);
        chk("b2b_upd", upd_count, exp_upd);

        // Clear with a pixel in S1.
        fill(9'd5);
        in_valid = 1'b1;
        in_x     = 4'd1;
        in_y     = 3'd1;
        in_cidx  = 9'd50;
        @(negedge clk);
        chk("clr_pix_ready", in_ready, 1);
        tick();
        clr_start = 1'b1;
        in_x      = 4'd2;
        in_y      = 3'd2;
        in_cidx   = 9'd60;
        @(negedge clk);
        chk("clr_t_ready", in_ready, 0);
        chk("clr_t_we", ram_we, 1);
        chk("clr_t_waddr", ram_waddr, 17);
        chk("clr_t_wdata", ram_wdata, 50);
        tick();
        clr_start = 1'b0;
        in_valid  = 1'b1;
        err = 0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || ram_we !== 1'b1 || ram_re !== 1'b0 ||
                in_ready !== 1'b0 || ram_waddr !== AW'(i) ||
                ram_wdata !== 9'd0 || upd_count !== 16'd0)
                err++;
            tick();
            clr_start = (i == 9);
        end
        clr_start = 1'b0;
        @(negedge clk);
        chk("clr_sweep_err", err, 0);
        chk("clr_end_busy", busy, 0);
        chk("clr_end_ready", in_ready, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_end_we", ram_we, 0);
        chk("clr_upd", upd_count, 0);
        err = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== 9'd0) err++;
        chk("clr_mem_zero", err, 0);

        // Reset in the middle of a sweep.
        fill(9'd7);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (20) tick();
        chk("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_ready", in_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("mid_rel_ready", in_ready, 1);
        chk("mid_rel_busy", busy, 0);
        chk("mid_mem_first", mem[0], 0);
        chk("mid_mem_last", mem[N-1], 7);

        // Random pixels vs reference model.
        tick();
        fill(9'd0);
        for (int i = 0; i < N; i++) refm[i] = 9'd0;
        exp_upd = 0;
        acc = 0;
        cyc = 0;
        in_valid = 1'b0;
        while (acc < 1000 && cyc < 20000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_x     = XW'($urandom_range(0, 3));
                in_y     = YW'($urandom_range(0, 1));
                in_cidx  = 9'($urandom_range(0, 511));
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                a = int'({in_y, in_x});
                if (in_cidx > refm[a]) begin
                    refm[a] = in_cidx;
                    exp_upd++;
                end
                acc++;
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("rnd_accepted", acc, 1000);
        tick();
        tick();
        tick();
        mism = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== refm[i]) mism++;
        chk("rnd_mem", mism, 0);
        chk("rnd_upd", upd_count, exp_upd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
